pipe_scheduler: RTL and testbench

Multi-pipe sequencer for the flappy game datapath. Holds NUM_PIPES pipe slots and advances them once per frame_tick while the game is running. Spawns new pipes at a fixed horizontal spacing by requesting gap heights from the PRNG over a req/ack handshake, retires pipes that leave the screen, and pulses score when a pipe's trailing edge passes the bird. Sits between the game-state FSM (run, clear) and the collision/render logic, which consume the pipe_x, pipe_y and pipe_valid vectors.

---
 rtl/flappy_pkg.sv | 35 +++
 rtl/free_slot_finder.sv | 25 ++
 rtl/pipe_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_pipe_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy game datapath.
package flappy_pkg;

    // Width of every screen coordinate carried through the datapath.
    localparam int COORD_W = 10;

    // Default number of pipe slots held by the scheduler.
    localparam int NUM_PIPES_DEFAULT = 3;

    // Pipe scheduler sequencing states.
    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        SPAWN_CHK,
        REQ
    } sched_state_t;

    // Clamp a raw coordinate into the closed range [lo, hi].
    function automatic logic [COORD_W-1:0] clamp_coord(
        input logic [COORD_W-1:0] value,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        logic [COORD_W-1:0] result;
        if (value < lo) begin
            result = lo;
        end else if (value > hi) begin
            result = hi;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/free_slot_finder.sv
// Lowest-index free slot priority encoder over the pipe valid vector.
module free_slot_finder
    import flappy_pkg::*;
#(
    parameter int NUM_PIPES = NUM_PIPES_DEFAULT,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_PIPES-1:0] pipe_valid,
    output logic                 any_free,
    output logic [IDX_W-1:0]     free_idx
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_PIPES - 1; i >= 0; i--) begin
            if (!pipe_valid[i]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pipe_scheduler.sv
// Multi-pipe sequencer: moves, retires, spawns and scores pipe slots once
// per frame while the game runs.
module pipe_scheduler
    import flappy_pkg::*;
#(
    parameter int NUM_PIPES    = NUM_PIPES_DEFAULT,
    parameter int SCREEN_WIDTH = 640,
    parameter int PIPE_WIDTH   = 30,
    parameter int PIPE_SPEED   = 4,
    parameter int SPAWN_GAP    = 220,
    parameter int BIRD_X       = 200,
    parameter int GAP_MIN_Y    = 40,
    parameter int GAP_MAX_Y    = 340
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           run,
    input  logic                           clear,
    input  logic                           frame_tick,
    output logic                           height_req,
    input  logic                           height_ack,
    input  logic [COORD_W-1:0]             height_in,
    output logic [COORD_W*NUM_PIPES-1:0]   pipe_x,
    output logic [COORD_W*NUM_PIPES-1:0]   pipe_y,
    output logic [NUM_PIPES-1:0]           pipe_valid,
    output logic                           score_pulse,
    output logic                           busy,
    output logic                           overrun
);

    localparam int IDX_W = (NUM_PIPES > 2) ? 2 : 1;
    localparam int SUM_W = COORD_W + 1;

    localparam logic [COORD_W-1:0] SPEED_C   = COORD_W'(PIPE_SPEED);
    localparam logic [COORD_W-1:0] SCREEN_C  = COORD_W'(SCREEN_WIDTH);
    localparam logic [COORD_W-1:0] GAP_C     = COORD_W'(SPAWN_GAP);
    localparam logic [COORD_W-1:0] MIN_Y_C   = COORD_W'(GAP_MIN_Y);
    localparam logic [COORD_W-1:0] MAX_Y_C   = COORD_W'(GAP_MAX_Y);
    localparam logic [SUM_W-1:0]   WIDTH_S   = SUM_W'(PIPE_WIDTH);
    localparam logic [SUM_W-1:0]   BIRD_S    = SUM_W'(BIRD_X);
    localparam logic [SUM_W-1:0]   SPEED_S   = SUM_W'(PIPE_SPEED);
    localparam logic [SUM_W-1:0]   GAP_S     = SUM_W'(SPAWN_GAP);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_PIPES - 1);

    sched_state_t state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [COORD_W-1:0] dist_q, dist_d;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;
    logic               req_q, req_d;
    logic               score_q, score_d;
    logic [COORD_W-1:0] x_q [NUM_PIPES];
    logic [COORD_W-1:0] x_d [NUM_PIPES];
    logic [COORD_W-1:0] y_q [NUM_PIPES];
    logic [COORD_W-1:0] y_d [NUM_PIPES];
    logic [NUM_PIPES-1:0] valid_q, valid_d;

    logic               any_free;
    logic [IDX_W-1:0]   free_idx;

    logic [COORD_W-1:0] moved_x;
    logic [SUM_W-1:0]   old_edge;
    logic [SUM_W-1:0]   new_edge;
    logic [SUM_W-1:0]   dist_sum;
    logic [COORD_W-1:0] dist_next;

    free_slot_finder #(
        .NUM_PIPES (NUM_PIPES),
        .IDX_W     (IDX_W)
    ) u_free_slot_finder (
        .pipe_valid (valid_q),
        .any_free   (any_free),
        .free_idx   (free_idx)
    );

    // Next-state logic: clear wins, then tick bookkeeping, then per-state work.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dist_d    = dist_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        req_d     = req_q;
        score_d   = 1'b0;
        x_d       = x_q;
        y_d       = y_q;
        valid_d   = valid_q;
        moved_x   = '0;
        old_edge  = '0;
        new_edge  = '0;
        dist_sum  = {1'b0, dist_q} + SPEED_S;
        dist_next = (dist_sum >= GAP_S) ? GAP_C : dist_sum[COORD_W-1:0];

        if (clear) begin
            state_d   = IDLE;
            idx_d     = '0;
            dist_d    = GAP_C;
            pending_d = 1'b0;
            overrun_d = 1'b0;
            req_d     = 1'b0;
            valid_d   = '0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                x_d[i] = '0;
                y_d[i] = '0;
            end
        end else begin
            if (state_q != IDLE && frame_tick) begin
                if (!pending_q) begin
                    pending_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (run && (frame_tick || pending_q)) begin
                        state_d   = MOVE;
                        idx_d     = '0;
                        pending_d = 1'b0;
                    end
                end

                MOVE: begin
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        if (IDX_W'(i) == idx_q && valid_q[i]) begin
                            if (x_q[i] < SPEED_C) begin
                                valid_d[i] = 1'b0;
                            end else begin
                                moved_x  = x_q[i] - SPEED_C;
                                x_d[i]   = moved_x;
                                old_edge = {1'b0, x_q[i]} + WIDTH_S;
                                new_edge = {1'b0, moved_x} + WIDTH_S;
                                if (old_edge >= BIRD_S && new_edge < BIRD_S) begin
                                    score_d = 1'b1;
                                end
                            end
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = SPAWN_CHK;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end

                SPAWN_CHK: begin
                    if (dist_next >= GAP_C && any_free) begin
                        state_d = REQ;
                        req_d   = 1'b1;
                    end else begin
                        dist_d  = dist_next;
                        state_d = IDLE;
                    end
                end

                REQ: begin
                    if (height_ack) begin
                        for (int i = 0; i < NUM_PIPES; i++) begin
                            if (IDX_W'(i) == free_idx) begin
                                valid_d[i] = 1'b1;
                                x_d[i]     = SCREEN_C;
                                y_d[i]     = clamp_coord(height_in, MIN_Y_C, MAX_Y_C);
                            end
                        end
                        dist_d  = '0;
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and slot registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            dist_q    <= GAP_C;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            req_q     <= 1'b0;
            score_q   <= 1'b0;
            valid_q   <= '0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dist_q    <= dist_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            req_q     <= req_d;
            score_q   <= score_d;
            valid_q   <= valid_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    // Pack the slot arrays onto the flat output vectors.
    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pack
        assign pipe_x[COORD_W*g +: COORD_W] = x_q[g];
        assign pipe_y[COORD_W*g +: COORD_W] = y_q[g];
    end

    assign pipe_valid  = valid_q;
    assign height_req  = req_q;
    assign score_pulse = score_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed, table-driven bench for the pipe scheduler. A second instance
// with a wider screen keeps pipes alive long enough to fill every slot.
module tb_pipe_scheduler;

    logic        clk;
    logic        reset;
    logic        run;
    logic        clear;
    logic        frame_tick;
    logic        height_req;
    logic        height_ack;
    logic [9:0]  height_in;
    logic [29:0] pipe_x;
    logic [29:0] pipe_y;
    logic [2:0]  pipe_valid;
    logic        score_pulse;
    logic        busy;
    logic        overrun;

    logic        sat_req;
    logic        sat_ack;
    logic [29:0] sat_x;
    logic [29:0] sat_y;
    logic [2:0]  sat_valid;
    logic        sat_score;
    logic        sat_busy;
    logic        sat_overrun;
    int          sat_acks;

    int passed_checks;
    int total_checks;

    typedef struct {
        int         frames;
        logic [9:0] h;
        int         reqs;
        int         scores;
        logic [2:0] valid;
        logic [9:0] x0, x1, x2;
        logic [9:0] y0, y1, y2;
        int         sat_acks;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    pipe_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .clear       (clear),
        .frame_tick  (frame_tick),
        .height_req  (height_req),
        .height_ack  (height_ack),
        .height_in   (height_in),
        .pipe_x      (pipe_x),
        .pipe_y      (pipe_y),
        .pipe_valid  (pipe_valid),
        .score_pulse (score_pulse),
        .busy        (busy),
        .overrun     (overrun)
    );

    pipe_scheduler #(.SCREEN_WIDTH(1020)) u_sat (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .clear       (clear),
        .frame_tick  (frame_tick),
        .height_req  (sat_req),
        .height_ack  (sat_ack),
        .height_in   (10'd100),
        .pipe_x      (sat_x),
        .pipe_y      (sat_y),
        .pipe_valid  (sat_valid),
        .score_pulse (sat_score),
        .busy        (sat_busy),
        .overrun     (sat_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Answer the wide-screen instance's height requests immediately.
    initial begin
        sat_ack  = 1'b0;
        sat_acks = 0;
        forever begin
            @(negedge clk);
            if (sat_req && !sat_ack) begin
                sat_ack = 1'b1;
                sat_acks++;
            end else begin
                sat_ack = 1'b0;
            end
        end
    end

    function automatic vec_t mk_vec(int frames, int h, int reqs, int scores, int valid,
                                    int x0, int x1, int x2, int y0, int y1, int y2, int sa);
        vec_t v;
        v.frames   = frames;
        v.h        = 10'(h);
        v.reqs     = reqs;
        v.scores   = scores;
        v.valid    = 3'(valid);
        v.x0       = 10'(x0);
        v.x1       = 10'(x1);
        v.x2       = 10'(x2);
        v.y0       = 10'(y0);
        v.y1       = 10'(y1);
        v.y2       = 10'(y2);
        v.sat_acks = sa;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual === expected) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One frame: pulse the tick, ack any request with h, wait for both instances to idle.
    task automatic applyStimulus(input logic [9:0] h, output int req_cnt, output int score_cnt,
                                 output int first_req);
        bit done;
        req_cnt   = 0;
        score_cnt = 0;
        first_req = -1;
        done      = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            if (k > 1) @(negedge clk);
            if (score_pulse) score_cnt++;
            if (height_req && !height_ack) begin
                height_ack = 1'b1;
                height_in  = h;
                req_cnt++;
                if (first_req < 0) first_req = k;
            end else begin
                height_ack = 1'b0;
            end
            if (!busy && !sat_busy && !height_ack) done = 1'b1;
        end
        checkOutput("frame_done", 32'(done), 32'd1);
        @(negedge clk);
        height_ack = 1'b0;
    endtask

    initial begin
        int r, s, fr, tot_r, tot_s;
        bit seen;

        passed_checks = 0;
        total_checks  = 0;
        reset      = 1'b0;
        run        = 1'b0;
        clear      = 1'b0;
        frame_tick = 1'b0;
        height_ack = 1'b0;
        height_in  = '0;

        vecs[0]  = mk_vec(54, 5,   0, 0, 3'b001, 424, 0,   0,   150, 0,   0,   1);
        vecs[1]  = mk_vec(1,  5,   1, 0, 3'b011, 420, 640, 0,   150, 40,  0,   2);
        vecs[2]  = mk_vec(54, 400, 0, 0, 3'b011, 204, 424, 0,   150, 40,  0,   2);
        vecs[3]  = mk_vec(1,  400, 1, 0, 3'b111, 200, 420, 640, 150, 40,  340, 3);
        vecs[4]  = mk_vec(7,  0,   0, 0, 3'b111, 172, 392, 612, 150, 40,  340, 3);
        vecs[5]  = mk_vec(1,  0,   0, 1, 3'b111, 168, 388, 608, 150, 40,  340, 3);
        vecs[6]  = mk_vec(10, 0,   0, 0, 3'b111, 128, 348, 568, 150, 40,  340, 3);
        vecs[7]  = mk_vec(32, 0,   0, 0, 3'b111, 0,   220, 440, 150, 40,  340, 3);
        vecs[8]  = mk_vec(1,  0,   0, 0, 3'b110, 0,   216, 436, 150, 40,  340, 3);
        vecs[9]  = mk_vec(3,  0,   0, 0, 3'b110, 0,   204, 424, 150, 40,  340, 3);
        vecs[10] = mk_vec(1,  77,  1, 0, 3'b111, 640, 200, 420, 77,  40,  340, 3);
        vecs[11] = mk_vec(90, 300, 1, 2, 3'b111, 280, 500, 60,  77,  300, 340, 3);
        vecs[12] = mk_vec(1,  300, 0, 0, 3'b111, 276, 496, 56,  77,  300, 340, 4);

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_pipe_x", 32'(pipe_x), 32'd0);
        checkOutput("rst_pipe_y", 32'(pipe_y), 32'd0);
        checkOutput("rst_valid", 32'(pipe_valid), 32'd0);
        checkOutput("rst_req", 32'(height_req), 32'd0);
        checkOutput("rst_score", 32'(score_pulse), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // A tick with run low is ignored
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        checkOutput("idle_ignores_tick", 32'(busy), 32'd0);

        // First frame spawns at once
        run = 1'b1;
        applyStimulus(10'd150, r, s, fr);
        checkOutput("first_req_latency", 32'(fr), 32'd5);
        checkOutput("first_reqs", 32'(r), 32'd1);
        checkOutput("first_valid", 32'(pipe_valid), 32'd1);
        checkOutput("first_x0", 32'(pipe_x[9:0]), 32'd640);
        checkOutput("first_y0", 32'(pipe_y[9:0]), 32'd150);
        checkOutput("first_busy", 32'(busy), 32'd0);
        checkOutput("first_sat_acks", 32'(sat_acks), 32'd1);

        // Table of frame chunks
        for (int v = 0; v < NV; v++) begin
            tot_r = 0;
            tot_s = 0;
            for (int f = 0; f < vecs[v].frames; f++) begin
                applyStimulus(vecs[v].h, r, s, fr);
                tot_r += r;
                tot_s += s;
            end
            checkOutput($sformatf("v%0d_reqs", v), 32'(tot_r), 32'(vecs[v].reqs));
            checkOutput($sformatf("v%0d_scores", v), 32'(tot_s), 32'(vecs[v].scores));
            checkOutput($sformatf("v%0d_valid", v), 32'(pipe_valid), 32'(vecs[v].valid));
            checkOutput($sformatf("v%0d_x0", v), 32'(pipe_x[9:0]), 32'(vecs[v].x0));
            checkOutput($sformatf("v%0d_x1", v), 32'(pipe_x[19:10]), 32'(vecs[v].x1));
            checkOutput($sformatf("v%0d_x2", v), 32'(pipe_x[29:20]), 32'(vecs[v].x2));
            checkOutput($sformatf("v%0d_y0", v), 32'(pipe_y[9:0]), 32'(vecs[v].y0));
            checkOutput($sformatf("v%0d_y1", v), 32'(pipe_y[19:10]), 32'(vecs[v].y1));
            checkOutput($sformatf("v%0d_y2", v), 32'(pipe_y[29:20]), 32'(vecs[v].y2));
            checkOutput($sformatf("v%0d_sat_acks", v), 32'(sat_acks), 32'(vecs[v].sat_acks));
        end
        checkOutput("sat_valid", 32'(sat_valid), 32'd7);
        checkOutput("sat_respawn_x0", 32'(sat_x[9:0]), 32'd1020);
        checkOutput("sat_respawn_y0", 32'(sat_y[9:0]), 32'd100);
        checkOutput("sat_score_idle", 32'(sat_score), 32'd0);

        // Two extra ticks during one sequence: one deferred run, one dropped
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("ovr_x0", 32'(pipe_x[9:0]), 32'd268);
        checkOutput("ovr_flag", 32'(overrun), 32'd1);
        checkOutput("ovr_sat_flag", 32'(sat_overrun), 32'd1);
        checkOutput("ovr_busy", 32'(busy), 32'd0);
        applyStimulus(10'd0, r, s, fr);
        checkOutput("ovr_after_x0", 32'(pipe_x[9:0]), 32'd264);
        checkOutput("ovr_sticky", 32'(overrun), 32'd1);

        // Clear in the middle of MOVE
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0; clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        checkOutput("clr_valid", 32'(pipe_valid), 32'd0);
        checkOutput("clr_pipe_x", 32'(pipe_x), 32'd0);
        checkOutput("clr_pipe_y", 32'(pipe_y), 32'd0);
        checkOutput("clr_busy", 32'(busy), 32'd0);
        checkOutput("clr_overrun", 32'(overrun), 32'd0);
        checkOutput("clr_req", 32'(height_req), 32'd0);

        // Spawn distance is re-armed by clear
        applyStimulus(10'd400, r, s, fr);
        checkOutput("clr_first_latency", 32'(fr), 32'd5);
        checkOutput("clr_first_valid", 32'(pipe_valid), 32'd1);
        checkOutput("clr_first_x0", 32'(pipe_x[9:0]), 32'd640);
        checkOutput("clr_first_y0", 32'(pipe_y[9:0]), 32'd340);
        tot_r = 0;
        for (int f = 0; f < 54; f++) begin
            applyStimulus(10'd0, r, s, fr);
            tot_r += r;
        end
        checkOutput("clr_no_early_req", 32'(tot_r), 32'd0);

        // Asynchronous reset while a request is outstanding
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            if (k > 1) @(negedge clk);
            if (height_req) seen = 1'b1;
        end
        checkOutput("req_before_reset", 32'(seen), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("arst_req", 32'(height_req), 32'd0);
        checkOutput("arst_valid", 32'(pipe_valid), 32'd0);
        checkOutput("arst_pipe_x", 32'(pipe_x), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
